comp_divider: RTL and testbench



---
 rtl/comp_divider.sv | 86 ++++++++
 tb/tb_comp_divider.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/comp_divider.sv
// comp_divider: sequential 32-bit unsigned restoring divider.
// One quotient bit per clock, 32 iterations, run/ready handshake.
module comp_divider (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Dividend,
   input  logic [31:0] Divisor,
   input  logic        run,
   output logic [31:0] Quotient,
   output logic [31:0] Remainder,
   output logic        ready,
   output logic        div_by_zero
);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t      state, state_n;
   logic [63:0] rem, rem_n;
   logic [31:0] dvs, dvs_n;
   logic [5:0]  cnt, cnt_n;
   logic        ready_n;
   logic        dbz_n;
   logic [63:0] s;
   logic [32:0] d;

   // High half never exceeds 2*dvs, so a no-borrow d fits in 32 bits
   assign s = {rem[62:0], 1'b0};
   assign d = {1'b0, s[63:32]} - {1'b0, dvs};

   assign Quotient  = rem[31:0];
   assign Remainder = rem[63:32];

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         rem         <= '0;
         dvs         <= '0;
         cnt         <= '0;
         ready       <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         state       <= state_n;
         rem         <= rem_n;
         dvs         <= dvs_n;
         cnt         <= cnt_n;
         ready       <= ready_n;
         div_by_zero <= dbz_n;
      end
   end

   always_comb begin
      state_n = state;
      rem_n   = rem;
      dvs_n   = dvs;
      cnt_n   = cnt;
      ready_n = ready;
      dbz_n   = div_by_zero;
      unique case (state)
         IDLE, DONE: begin
            if (run) begin
               rem_n   = {32'b0, Dividend};
               dvs_n   = Divisor;
               cnt_n   = '0;
               ready_n = 1'b0;
               dbz_n   = (Divisor == 32'b0);
               state_n = CALC;
            end
         end
         CALC: begin
            if (!d[32]) rem_n = {d[31:0], s[31:1], 1'b1};
            else        rem_n = s;
            cnt_n = cnt + 6'd1;
            if (cnt == 6'd31) begin
               state_n = DONE;
               ready_n = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_comp_divider.sv
// tb_comp_divider: vector table plus scoreboard bench for comp_divider.
// Checks results, latency, handshake, reset abort and random operands.
module tb_comp_divider;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Dividend;
   logic [31:0] Divisor;
   logic        run;
   logic [31:0] Quotient;
   logic [31:0] Remainder;
   logic        ready;
   logic        div_by_zero;

   int pass_cnt = 0;
   int total_cnt = 0;

   typedef struct {
      logic [31:0] dvd;
      logic [31:0] dvs;
      logic [31:0] q;
      logic [31:0] r;
      logic        z;
   } vec_t;

   vec_t sb[$];
   vec_t tbl[10];

   comp_divider dut (
      .clk        (clk),
      .reset      (reset),
      .Dividend   (Dividend),
      .Divisor    (Divisor),
      .run        (run),
      .Quotient   (Quotient),
      .Remainder  (Remainder),
      .ready      (ready),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b);
      vec_t v;
      v.dvd = a;
      v.dvs = b;
      if (b == 0) begin
         v.q = 32'hFFFF_FFFF;
         v.r = a;
         v.z = 1'b1;
      end else begin
         v.q = a / b;
         v.r = a % b;
         v.z = 1'b0;
      end
      return v;
   endfunction

   // Drives a one-cycle start pulse and queues the expected result
   task automatic start(input vec_t v);
      @(negedge clk);
      Dividend = v.dvd;
      Divisor  = v.dvs;
      run      = 1'b1;
      sb.push_back(v);
      @(posedge clk);
      #1;
      chk("ready_drop_on_start", {31'b0, ready}, 32'd0);
      @(negedge clk);
      run = 1'b0;
   endtask

   task automatic wait_result(input bit disturb);
      vec_t e;
      int n;
      n = 0;
      while (n < 40) begin
         @(posedge clk);
         #1;
         n++;
         if (ready) break;
         if (disturb) begin
            Dividend = $urandom;
            Divisor  = $urandom;
            run      = (n < 28) ? n[0] : 1'b0;
         end
      end
      if (!ready) $display("FAIL timeout: ready not seen after %0d edges", n);
      chk("latency", n, 32);
      e = sb.pop_front();
      chk("quotient", Quotient, e.q);
      chk("remainder", Remainder, e.r);
      chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.z});
   endtask

   initial begin
      reset    = 1'b1;
      run      = 1'b0;
      Dividend = '0;
      Divisor  = '0;

      tbl[0] = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
      tbl[1] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0};
      tbl[2] = '{32'd5, 32'd9, 32'd0, 32'd5, 1'b0};
      tbl[3] = '{32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1};
      tbl[4] = '{32'd10, 32'd3, 32'd3, 32'd1, 1'b0};
      tbl[5] = '{32'd0, 32'd5, 32'd0, 32'd0, 1'b0};
      tbl[6] = '{32'd7, 32'd7, 32'd1, 32'd0, 1'b0};
      tbl[7] = '{32'd1, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0};
      tbl[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0};
      tbl[9] = '{32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF,
                 32'h0000_FFFF, 1'b0};

      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("reset_ready", {31'b0, ready}, 32'd0);
      chk("reset_q", Quotient, 32'd0);
      chk("reset_r", Remainder, 32'd0);
      chk("reset_dbz", {31'b0, div_by_zero}, 32'd0);

      // Back-to-back: each start lands on the edge after ready is seen
      for (int i = 0; i < 10; i++) begin
         start(tbl[i]);
         wait_result(1'b0);
      end

      // DONE holds its result while run stays low
      repeat (5) @(posedge clk);
      #1;
      chk("done_hold_ready", {31'b0, ready}, 32'd1);
      chk("done_hold_q", Quotient, 32'h0000_FFFF);
      chk("done_hold_r", Remainder, 32'h0000_FFFF);

      // Inputs and run churn during CALC must not disturb the result
      start(mk(32'd1000, 32'd10));
      wait_result(1'b1);

      // Reset at iteration 15 aborts the division
      start(mk(32'h8000_0000, 32'd3));
      repeat (14) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      void'(sb.pop_front());
      chk("abort_ready", {31'b0, ready}, 32'd0);
      chk("abort_q", Quotient, 32'd0);
      chk("abort_r", Remainder, 32'd0);
      repeat (40) @(posedge clk);
      #1;
      chk("abort_idle_ready", {31'b0, ready}, 32'd0);
      chk("abort_idle_q", Quotient, 32'd0);
      start(mk(32'h8000_0000, 32'd3));
      wait_result(1'b0);

      for (int i = 0; i < 300; i++) begin
         logic [31:0] a, b;
         a = $urandom;
         b = (i % 4 == 0) ? ($urandom & 32'hFF) : $urandom;
         if (i % 50 == 7) b = 32'd0;
         start(mk(a, b));
         wait_result(1'b0);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
